router_pkt_tx: RTL and testbench
================================

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have reset  in  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have start  in  1  packet request, accepted when tx_ready=1.
REQ-004 SHALL have len  in  6  payload length in bytes, sampled with start.
REQ-005 SHALL have addr  in  2  destination port (0..2), sampled with start.
REQ-006 SHALL have pld_data  in  8  upstream payload byte.
REQ-007 SHALL have pld_valid  in  1  upstream byte valid.
REQ-008 SHALL have pld_ready  out  1  block accepts upstream byte.
REQ-009 SHALL have busy  in  1  router busy; byte on pkt_data not consumed while high.
REQ-010 SHALL have pkt_data  out  8  byte to router data_in.
REQ-011 SHALL have pkt_valid  out  1  to router pkt_valid; high for header and payload bytes only.
REQ-012 SHALL have tx_ready  out  1  high only in IDLE.
REQ-013 SHALL have done  out  1  one-cycle pulse after parity transferred.
REQ-014 SHALL have err  out  1  one-cycle pulse on rejected request.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> HDR -> PLD -> PAR -> IDLE; pkt_data, pkt_valid, pld_ready, tx_ready, done, err SHALL be driven from registers only.
REQ-016 SHALL accept start at an edge in IDLE; if addr=3 or len=0, pulse err next cycle and remain IDLE; otherwise latch len, addr and enter LOAD.
REQ-017 SHALL hold pld_ready=1 in LOAD; each edge with pld_valid=pld_ready=1 stores pld_data into a 64x8 buffer at a 6-bit write index; gaps in pld_valid are tolerated.
REQ-018 SHALL compute parity = header XOR all payload bytes, header = {len, addr}.
REQ-019 SHALL enter HDR the cycle after the len-th byte is stored; pld_ready=0 outside LOAD.
REQ-020 SHALL present one byte at a time; a byte is transferred at an edge where busy=0; while busy=1, pkt_data and pkt_valid SHALL hold unchanged (no drop, no duplication).
REQ-021 SHALL drive HDR: pkt_data=header, pkt_valid=1; PLD: buffer bytes 0..len-1 in order, pkt_valid=1; PAR: pkt_data=parity, pkt_valid=0.
REQ-022 SHALL, on parity transfer, return to IDLE with done=1 and tx_ready=1 in that same next cycle; IDLE drives pkt_data=0x00, pkt_valid=0.
REQ-023 SHALL ignore start outside IDLE.
REQ-024 SHALL handle len=63 without index wrap errors (last byte at index 62, count reaches 63 exactly).

Reset
REQ-025 SHALL, on reset assertion at any time including mid-packet, immediately force IDLE, pkt_data=0x00, pkt_valid=0, pld_ready=0, done=0, err=0, tx_ready=1 after release; any partial packet is abandoned; buffer contents need not be cleared.

Configuration
REQ-026 SHALL, with ROUTER_TX_PARITY_INJ_EN defined, add input corrupt_parity (1 bit), sampled with an accepted start; if high, the transmitted parity byte SHALL be true parity XOR 0x01.
REQ-027 SHALL, without ROUTER_TX_PARITY_INJ_EN, omit the corrupt_parity port and always transmit true parity.

Verification
REQ-028 SHALL verify: start len=10 addr=0, pld bytes 0x01..0x0A, busy=0 -> pkt_data 0x28,0x01..0x0A with pkt_valid=1 (11 transfers), then 0x23 with pkt_valid=0, done pulse next cycle.
REQ-029 SHALL verify: busy=1 for 3 cycles while payload byte 5 presented -> byte held 4 cycles, pkt_valid stays 1, byte appears once.
REQ-030 SHALL verify: start addr=3, then start len=0 addr=1 -> err pulse each, pkt_valid never asserted, tx_ready stays 1.
REQ-031 SHALL verify: len=63 addr=2 with pld_valid toggling every other cycle -> no pkt_valid until 63rd byte stored, header 0xFE, 63 payload bytes in order.
REQ-032 SHALL verify: reset asserted mid-PLD -> pkt_valid=0 same cycle; next len=4 packet transmits correctly.
REQ-033 SHALL verify with ROUTER_TX_PARITY_INJ_EN: REQ-028 stimulus plus corrupt_parity=1 -> parity byte 0x22.

Source files
------------

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet transmitter in front of a router input port.
//
// A request (start with len/addr) is accepted only in IDLE. The payload
// is first collected from upstream into a 64x8 buffer, then sent as
// header {len, addr}, payload bytes 0..len-1, and the parity byte
// (header XOR all payload bytes). The router consumes a byte at any
// rising edge where busy=0. While busy=1 the presented byte and its
// valid flag hold unchanged.
//
// Handshakes:
//   upstream : a byte moves at a rising edge with pld_valid=1 and
//              pld_ready=1; pld_ready is high only while collecting.
//   router   : pkt_data/pkt_valid are presented and move at a rising
//              edge with busy=0. pkt_valid is high for header and
//              payload only; the parity byte goes out with pkt_valid=0.
//
// Optional feature (macro ROUTER_TX_PARITY_INJ_EN): adds input
// corrupt_parity, sampled with an accepted start; when set, the sent
// parity byte is the true parity XOR 0x01.
//
// Ports:
//   clock, reset            clock and asynchronous active-high reset
//   start, len[5:0], addr   packet request and its parameters
//   corrupt_parity          (optional) parity error injection
//   pld_data, pld_valid     upstream payload byte
//   pld_ready               block accepts an upstream byte
//   busy                    router cannot take a byte this cycle
//   pkt_data, pkt_valid     byte and valid flag to the router
//   tx_ready                high only in IDLE
//   done                    one-cycle pulse after the parity byte moves
//   err                     one-cycle pulse on a rejected request
//   dbg_state               current FSM state
module router_pkt_tx (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] len,
  input  logic [1:0] addr,
`ifdef ROUTER_TX_PARITY_INJ_EN
  input  logic       corrupt_parity,
`endif
  input  logic [7:0] pld_data,
  input  logic       pld_valid,
  output logic       pld_ready,
  input  logic       busy,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HDR  = 3'd2,
    S_PLD  = 3'd3,
    S_PAR  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] len_q, len_d;
  logic [1:0] addr_q, addr_d;
  logic [5:0] wr_q, wr_d;
  logic [5:0] rd_q, rd_d;
  logic [7:0] par_q, par_d;
  logic       inj_q, inj_d;
  logic [7:0] pkt_data_d;
  logic       pkt_valid_d, pld_ready_d, tx_ready_d, done_d, err_d;
  logic       wr_en;

  logic [7:0] mem [64];

  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    par_d       = par_q;
    inj_d       = inj_q;
    pkt_data_d  = pkt_data;
    pkt_valid_d = pkt_valid;
    pld_ready_d = pld_ready;
    tx_ready_d  = tx_ready;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wr_en       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (addr == 2'd3 || len == 6'd0) begin
            err_d = 1'b1;
          end else begin
            state_d     = S_LOAD;
            len_d       = len;
            addr_d      = addr;
            wr_d        = 6'd0;
            // parity accumulator starts from the header byte
            par_d       = {len, addr};
`ifdef ROUTER_TX_PARITY_INJ_EN
            inj_d       = corrupt_parity;
`else
            inj_d       = 1'b0;
`endif
            pld_ready_d = 1'b1;
            tx_ready_d  = 1'b0;
          end
        end
      end
      S_LOAD: begin
        if (pld_valid && pld_ready) begin
          wr_en = 1'b1;
          wr_d  = wr_q + 6'd1;
          par_d = par_q ^ pld_data;
          // last byte stored at this edge: header goes out next cycle
          if (wr_q + 6'd1 == len_q) begin
            state_d     = S_HDR;
            pld_ready_d = 1'b0;
            pkt_data_d  = {len_q, addr_q};
            pkt_valid_d = 1'b1;
          end
        end
      end
      S_HDR: begin
        if (!busy) begin
          state_d    = S_PLD;
          pkt_data_d = mem[6'd0];
          rd_d       = 6'd1;
        end
      end
      S_PLD: begin
        // rd_q is the index of the next byte to present; reaching len_q
        // means the byte now on the bus is the last payload byte
        if (!busy) begin
          if (rd_q == len_q) begin
            state_d     = S_PAR;
            pkt_data_d  = par_q ^ {7'd0, inj_q};
            pkt_valid_d = 1'b0;
          end else begin
            pkt_data_d = mem[rd_q];
            rd_d       = rd_q + 6'd1;
          end
        end
      end
      S_PAR: begin
        if (!busy) begin
          state_d    = S_IDLE;
          pkt_data_d = 8'h00;
          done_d     = 1'b1;
          tx_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= 6'd0;
      addr_q    <= 2'd0;
      wr_q      <= 6'd0;
      rd_q      <= 6'd0;
      par_q     <= 8'h00;
      inj_q     <= 1'b0;
      pkt_data  <= 8'h00;
      pkt_valid <= 1'b0;
      pld_ready <= 1'b0;
      tx_ready  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      par_q     <= par_d;
      inj_q     <= inj_d;
      pkt_data  <= pkt_data_d;
      pkt_valid <= pkt_valid_d;
      pld_ready <= pld_ready_d;
      tx_ready  <= tx_ready_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // payload buffer: contents survive reset, only the indices are cleared
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_q] <= pld_data;
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] len;
  logic [1:0] addr;
  logic       corrupt_parity;
  logic [7:0] pld_data;
  logic       pld_valid;
  logic       pld_ready;
  logic       busy;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       tx_ready;
  logic       done;
  logic       err;
  logic [2:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // expected router-side transfers: {pkt_valid, pkt_data}
  logic [8:0] exp_q[$];

  router_pkt_tx dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .len            (len),
    .addr           (addr),
`ifdef ROUTER_TX_PARITY_INJ_EN
    .corrupt_parity (corrupt_parity),
`endif
    .pld_data       (pld_data),
    .pld_valid      (pld_valid),
    .pld_ready      (pld_ready),
    .busy           (busy),
    .pkt_data       (pkt_data),
    .pkt_valid      (pkt_valid),
    .tx_ready       (tx_ready),
    .done           (done),
    .err            (err),
    .dbg_state      (dbg_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one packet end to end and checks the router-side stream.
  // gap_mode: 0 continuous, 1 pld_valid toggling, 2 random gaps
  // busy_mode: 0 never busy, 1 random busy
  // hold_idx: transfer index (0 = header) held by busy for 3 cycles
  // abort_idx: transfer index at which reset is asserted (-1 = none)
  task automatic run_packet(input int plen, input int paddr, input int gap_mode,
                            input int busy_mode, input int hold_idx, input int abort_idx,
                            input int pay_mode, input bit corrupt);
    logic [7:0] pl [64];
    logic [7:0] par;
    logic [8:0] got, prev, e;
    int idx, cyc, n_x, held;
    bit tog, v, b, hv;

    for (int i = 0; i < plen; i++)
      pl[i] = (pay_mode != 0) ? 8'($urandom_range(0, 255)) : 8'(i + 1);
    par = {6'(plen), 2'(paddr)};
    for (int i = 0; i < plen; i++) par = par ^ pl[i];
    if (corrupt) par = par ^ 8'h01;
    exp_q.delete();
    exp_q.push_back({1'b1, 6'(plen), 2'(paddr)});
    for (int i = 0; i < plen; i++) exp_q.push_back({1'b1, pl[i]});
    exp_q.push_back({1'b0, par});

    @(negedge clock);
    chk("idle_rdy", 16'(tx_ready), 16'd1);
    start = 1'b1;
    len = 6'(plen);
    addr = 2'(paddr);
    corrupt_parity = corrupt;
    @(negedge clock);
    start = 1'b0;
    chk("acc_rdy", 16'(tx_ready), 16'd0);

    // collect phase: nothing may reach the router yet
    idx = 0; cyc = 0; tog = 1'b0;
    while (idx < plen && cyc < 1000) begin
      chk("load_pv", 16'(pkt_valid), 16'd0);
      chk("load_prdy", 16'(pld_ready), 16'd1);
      chk("load_err", 16'(err), 16'd0);
      case (gap_mode)
        0: v = 1'b1;
        1: begin v = tog; tog = ~tog; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      pld_valid = v;
      pld_data = v ? pl[idx] : 8'($urandom_range(0, 255));
      start = ($urandom_range(0, 3) == 0);
      len = 6'($urandom_range(0, 63));
      addr = 2'($urandom_range(0, 3));
      @(negedge clock);
      cyc++;
      if (v) idx++;
    end
    chk("load_timeout", 16'(idx), 16'(plen));
    pld_valid = 1'b0;

    // transmit phase
    n_x = 0; held = 0; hv = 1'b0; cyc = 0; prev = '0;
    while (exp_q.size() > 0 && cyc < 1000) begin
      got = {pkt_valid, pkt_data};
      chk("tx_prdy", 16'(pld_ready), 16'd0);
      chk("tx_rdy", 16'(tx_ready), 16'd0);
      chk("tx_err", 16'(err), 16'd0);
      if (hv) chk("hold", 16'(got), 16'(prev));
      if (n_x == abort_idx) begin
        reset = 1'b1;
        #1;
        chk("rst_pv", 16'(pkt_valid), 16'd0);
        chk("rst_pd", 16'(pkt_data), 16'd0);
        chk("rst_prdy", 16'(pld_ready), 16'd0);
        chk("rst_rdy_in", 16'(tx_ready), 16'd1);
        start = 1'b0;
        busy = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_rdy", 16'(tx_ready), 16'd1);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_pv2", 16'(pkt_valid), 16'd0);
        return;
      end
      if (n_x == hold_idx && held < 3) begin
        b = 1'b1;
        held++;
      end else if (busy_mode != 0) begin
        b = ($urandom_range(0, 2) == 0);
      end else begin
        b = 1'b0;
      end
      busy = b;
      start = ($urandom_range(0, 3) == 0);
      len = 6'($urandom_range(0, 63));
      addr = 2'($urandom_range(0, 3));
      if (!b) begin
        e = exp_q.pop_front();
        chk("xfer", 16'(got), 16'(e));
        n_x++;
        hv = 1'b0;
      end else begin
        prev = got;
        hv = 1'b1;
      end
      @(negedge clock);
      cyc++;
    end
    chk("tx_timeout", 16'(exp_q.size()), 16'd0);
    busy = 1'b0;
    start = 1'b0;
    chk("done", 16'(done), 16'd1);
    chk("end_rdy", 16'(tx_ready), 16'd1);
    chk("end_pv", 16'(pkt_valid), 16'd0);
    chk("end_pd", 16'(pkt_data), 16'd0);
    @(negedge clock);
    chk("done_clr", 16'(done), 16'd0);
    chk("end_err", 16'(err), 16'd0);
  endtask

  task automatic req_err(input int plen, input int paddr);
    @(negedge clock);
    start = 1'b1;
    len = 6'(plen);
    addr = 2'(paddr);
    @(negedge clock);
    start = 1'b0;
    chk("err_pulse", 16'(err), 16'd1);
    chk("err_rdy", 16'(tx_ready), 16'd1);
    chk("err_pv", 16'(pkt_valid), 16'd0);
    chk("err_prdy", 16'(pld_ready), 16'd0);
    @(negedge clock);
    chk("err_clr", 16'(err), 16'd0);
    chk("err_rdy2", 16'(tx_ready), 16'd1);
    chk("err_pv2", 16'(pkt_valid), 16'd0);
  endtask

  initial begin
    bit c;
    reset = 1'b1;
    start = 1'b0;
    busy = 1'b0;
    pld_valid = 1'b0;
    pld_data = 8'h00;
    len = 6'd0;
    addr = 2'd0;
    corrupt_parity = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_pv", 16'(pkt_valid), 16'd0);
    chk("rst_pd", 16'(pkt_data), 16'd0);
    chk("rst_prdy", 16'(pld_ready), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_rdy", 16'(tx_ready), 16'd1);

    // len=10 addr=0, bytes 0x01..0x0A, no backpressure
    run_packet(10, 0, 0, 0, -1, -1, 0, 1'b0);
    // busy held 3 cycles while payload byte 5 is presented
    run_packet(10, 0, 0, 0, 6, -1, 0, 1'b0);
    // rejected requests
    req_err(5, 3);
    req_err(0, 1);
    // longest packet with pld_valid toggling
    run_packet(63, 2, 1, 0, -1, -1, 1, 1'b0);
    // reset in the middle of payload, then a short packet
    run_packet(20, 1, 0, 1, -1, 8, 1, 1'b0);
    run_packet(4, 1, 2, 1, -1, -1, 1, 1'b0);
`ifdef ROUTER_TX_PARITY_INJ_EN
    run_packet(10, 0, 0, 0, -1, -1, 0, 1'b1);
`endif
    // randomized packets
    for (int k = 0; k < 12; k++) begin
`ifdef ROUTER_TX_PARITY_INJ_EN
      c = 1'($urandom_range(0, 1));
`else
      c = 1'b0;
`endif
      run_packet($urandom_range(1, 63), $urandom_range(0, 2), 2, 1,
                 ($urandom_range(0, 1) != 0) ? $urandom_range(0, 5) : -1, -1, 1, c);
    end
    req_err($urandom_range(1, 63), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
